// File: rtl/scratch_ram_gen.sv
// Parametrised CPU scratch RAM: one read/write CPU port, one registered read-only monitor port,
// and an optional clear sweep of the whole array after reset.
`timescale 1ns/1ps
module scratch_ram_gen #(
  parameter int unsigned       ADDR_W         = 7,
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       READ_LATENCY   = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              cs,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic [DATA_W-1:0] mon_data,
  output logic              busy,
  output logic              clear_done
);

  localparam int unsigned       Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CntOne  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CntLast = '1;

  typedef enum logic {StClear, StIdle} state_e;

  localparam state_e StReset = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mon_q;
  logic              clearing;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] mem [Depth];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clear_done = 1'b0;
    case (state_q)
      StClear: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          clear_done = 1'b1;
          state_d    = StIdle;
          cnt_d      = '0;
        end
      end
      StIdle:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign clearing = (state_q == StClear);
  assign busy     = clearing;

  // CPU writes are simply dropped while the sweep owns the write port.
  assign we    = clearing | (cs & ~rw);
  assign waddr = clearing ? cnt_q : address;
  assign wdata = clearing ? CLEAR_VALUE : data_in;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StReset;
      cnt_q   <= '0;
      mon_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mon_q   <= mem[mon_addr];
    end
  end

  assign mon_data = mon_q;

  if (READ_LATENCY == 0) begin : g_async_read
    assign data_out = clearing ? CLEAR_VALUE : mem[address];
  end else begin : g_sync_read
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else if (clearing) begin
        dout_q <= CLEAR_VALUE;
      end else if (cs && rw) begin
        dout_q <= mem[address];
      end
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_scratch_ram_gen.sv
// Bench for scratch_ram_gen: three configurations (async read, registered read, no clear sweep).
`timescale 1ns/1ps
module tb_scratch_ram_gen;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // A: defaults
  logic       a_rst, a_cs, a_rw, a_busy, a_done;
  logic [6:0] a_addr, a_maddr;
  logic [7:0] a_din, a_dout, a_mdata;
  // B: registered read, 16x16
  logic        b_rst, b_cs, b_rw, b_busy, b_done;
  logic [3:0]  b_addr, b_maddr;
  logic [15:0] b_din, b_dout, b_mdata;
  // C: no sweep, clear value 0xFF
  logic       c_rst, c_cs, c_rw, c_busy, c_done;
  logic [6:0] c_addr, c_maddr;
  logic [7:0] c_din, c_dout, c_mdata;

  scratch_ram_gen u_a (
    .clk(clk), .rst(a_rst), .address(a_addr), .cs(a_cs), .rw(a_rw), .data_in(a_din),
    .data_out(a_dout), .mon_addr(a_maddr), .mon_data(a_mdata), .busy(a_busy),
    .clear_done(a_done)
  );

  scratch_ram_gen #(.ADDR_W(4), .DATA_W(16), .READ_LATENCY(1)) u_b (
    .clk(clk), .rst(b_rst), .address(b_addr), .cs(b_cs), .rw(b_rw), .data_in(b_din),
    .data_out(b_dout), .mon_addr(b_maddr), .mon_data(b_mdata), .busy(b_busy),
    .clear_done(b_done)
  );

  scratch_ram_gen #(.CLEAR_ON_RESET(0), .CLEAR_VALUE(8'hFF)) u_c (
    .clk(clk), .rst(c_rst), .address(c_addr), .cs(c_cs), .rw(c_rw), .data_in(c_din),
    .data_out(c_dout), .mon_addr(c_maddr), .mon_data(c_mdata), .busy(c_busy),
    .clear_done(c_done)
  );

  int c_done_n = 0;
  int c_busy_n = 0;
  always @(posedge clk) begin
    if (c_done) c_done_n++;
    if (c_busy && c_rst) c_busy_n++;
  end

  logic [7:0]  model_a [128];
  logic [15:0] model_b [16];

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;  // write data, or expected read data
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Releases A's reset and counts busy cycles and clear_done pulses until busy drops.
  task automatic sweep_a(output int busy_n, output int pulses, output int pulse_at);
    busy_n = 0;
    pulses = 0;
    pulse_at = 0;
    @(negedge clk);
    a_rst = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      #1;
      if (!a_busy) break;
      busy_n++;
      if (a_done) begin
        pulses++;
        pulse_at = i;
      end
      @(negedge clk);
    end
    a_cs = 1'b0;
  endtask

  task automatic check_a_all(input string name);
    a_cs = 1'b0;
    for (int i = 0; i < 128; i++) begin
      a_addr = 7'(i);
      #1;
      chk(name, 32'(a_dout), 32'(model_a[i]));
    end
  endtask

  int bn, pn, pat;
  logic [7:0]  mon_exp_a;
  logic [15:0] mon_exp_b, dout_exp_b;

  initial begin
    tbl[0] = '{1'b1, 7'h7F, 8'h5A};
    tbl[1] = '{1'b1, 7'h00, 8'hA5};
    tbl[2] = '{1'b0, 7'h7F, 8'h5A};
    tbl[3] = '{1'b0, 7'h00, 8'hA5};
    tbl[4] = '{1'b0, 7'h10, 8'hAA};
    tbl[5] = '{1'b1, 7'h20, 8'h11};
    tbl[6] = '{1'b0, 7'h20, 8'h11};
    tbl[7] = '{1'b0, 7'h7F, 8'h5A};

    a_rst = 0; a_cs = 1; a_rw = 0; a_addr = 7'h10; a_din = 8'hAA; a_maddr = 0;
    b_rst = 0; b_cs = 0; b_rw = 0; b_addr = 0; b_din = 0; b_maddr = 0;
    c_rst = 0; c_cs = 0; c_rw = 0; c_addr = 0; c_din = 0; c_maddr = 0;

    repeat (3) @(negedge clk);
    chk("rst_a_busy", 32'(a_busy), 1);
    chk("rst_a_done", 32'(a_done), 0);
    chk("rst_a_mon", 32'(a_mdata), 0);
    chk("rst_b_dout", 32'(b_dout), 0);
    chk("rst_b_mon", 32'(b_mdata), 0);
    chk("rst_b_busy", 32'(b_busy), 1);
    chk("rst_c_busy", 32'(c_busy), 0);

    // C: no sweep, write in the first cycle after release
    @(negedge clk);
    c_rst = 1; c_cs = 1; c_rw = 0; c_addr = 7'h05; c_din = 8'h01; c_maddr = 7'h05;
    #1 chk("c_busy_after_rel", 32'(c_busy), 0);
    @(negedge clk);
    c_cs = 0;
    #1 chk("c_read_05", 32'(c_dout), 32'h01);
    @(negedge clk);
    chk("c_mon_05", 32'(c_mdata), 32'h01);

    // A: sweep with a write held on the CPU port throughout
    sweep_a(bn, pn, pat);
    chk("a_sweep_busy_cycles", 32'(bn), 128);
    chk("a_sweep_pulses", 32'(pn), 1);
    chk("a_sweep_pulse_cycle", 32'(pat), 128);
    chk("a_dropped_write", 32'(a_dout), 0);
    for (int i = 0; i < 128; i++) model_a[i] = 8'h00;
    @(negedge clk);
    a_cs = 1; a_rw = 0; a_addr = 7'h10; a_din = 8'hAA;
    @(negedge clk);
    a_cs = 0; model_a[7'h10] = 8'hAA;
    #1 chk("a_fresh_write", 32'(a_dout), 32'hAA);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        @(negedge clk);
        a_cs = 1; a_rw = 0; a_addr = tbl[i].addr; a_din = tbl[i].data;
        @(negedge clk);
        a_cs = 0;
        model_a[tbl[i].addr] = tbl[i].data;
      end else begin
        a_cs = 0; a_rw = 1; a_addr = tbl[i].addr;
        #1 chk($sformatf("a_tbl%0d", i), 32'(a_dout), 32'(tbl[i].data));
      end
    end

    // Monitor read-first: same-edge write shows up one edge later
    @(negedge clk);
    a_maddr = 7'h20; a_cs = 1; a_rw = 0; a_addr = 7'h20; a_din = 8'h22;
    @(negedge clk);
    a_cs = 0; model_a[7'h20] = 8'h22;
    chk("a_mon_old", 32'(a_mdata), 32'h11);
    @(negedge clk);
    chk("a_mon_new", 32'(a_mdata), 32'h22);

    // A: random traffic against the array model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n > 0) chk("a_rand_mon", 32'(a_mdata), 32'(mon_exp_a));
      a_cs = 1'($urandom); a_rw = 1'($urandom); a_addr = 7'($urandom);
      a_din = 8'($urandom); a_maddr = 7'($urandom);
      #1 chk("a_rand_dout", 32'(a_dout), 32'(model_a[a_addr]));
      @(posedge clk);
      mon_exp_a = model_a[a_maddr];
      if (a_cs && !a_rw) model_a[a_addr] = a_din;
    end
    @(negedge clk);
    a_cs = 0;
    chk("a_rand_mon_last", 32'(a_mdata), 32'(mon_exp_a));

    // A: reset mid-sweep restarts the sweep from scratch
    a_rst = 0;
    @(negedge clk);
    a_rst = 1;
    repeat (50) @(negedge clk);
    a_rst = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("a_abort_busy", 32'(a_busy), 1);
      chk("a_abort_done", 32'(a_done), 0);
      @(negedge clk);
    end
    sweep_a(bn, pn, pat);
    chk("a_resweep_busy_cycles", 32'(bn), 128);
    chk("a_resweep_pulses", 32'(pn), 1);
    chk("a_resweep_pulse_cycle", 32'(pat), 128);
    for (int i = 0; i < 128; i++) model_a[i] = 8'h00;
    check_a_all("a_cleared");

    // B: 16-word sweep, then registered reads
    @(negedge clk);
    b_rst = 1;
    bn = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!b_busy) break;
      bn++;
      @(negedge clk);
    end
    chk("b_sweep_cycles", 32'(bn), 16);
    for (int i = 0; i < 16; i++) model_b[i] = 16'h0000;
    @(negedge clk);
    b_cs = 1; b_rw = 0; b_addr = 4'h3; b_din = 16'h1234;
    @(negedge clk);
    b_rw = 1;
    #1 chk("b_before_read", 32'(b_dout), 0);
    @(negedge clk);
    chk("b_read_1234", 32'(b_dout), 32'h1234);
    b_cs = 0; b_addr = 4'h0;
    @(negedge clk);
    chk("b_hold_1", 32'(b_dout), 32'h1234);
    @(negedge clk);
    chk("b_hold_2", 32'(b_dout), 32'h1234);
    model_b[3] = 16'h1234;
    dout_exp_b = 16'h1234;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      chk("b_rand_dout", 32'(b_dout), 32'(dout_exp_b));
      if (n > 0) chk("b_rand_mon", 32'(b_mdata), 32'(mon_exp_b));
      b_cs = 1'($urandom); b_rw = 1'($urandom); b_addr = 4'($urandom);
      b_din = 16'($urandom); b_maddr = 4'($urandom);
      @(posedge clk);
      mon_exp_b = model_b[b_maddr];
      if (b_cs && b_rw) dout_exp_b = model_b[b_addr];
      if (b_cs && !b_rw) model_b[b_addr] = b_din;
    end
    @(negedge clk);
    b_cs = 0;
    chk("b_rand_dout_last", 32'(b_dout), 32'(dout_exp_b));

    chk("c_done_never", 32'(c_done_n), 0);
    chk("c_busy_never", 32'(c_busy_n), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
